fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch and next-PC stage of the extended single-cycle MIPS core.
- Holds the PC, fetches from instruction memory over a req/valid handshake, and presents the instruction word (opcode/funct) to the main decoder.
- Consumes the decoder's branch[1:0], jump, jpc, memread and statusregwrite outputs, together with datapath values, to compute the next PC and link address.
- Owns the status flag register (Z, N) used by balrn.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC / address width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  ADDR_W  fetch address (= PC)
imem_valid  in  1  instruction memory returns imem_rdata this cycle
imem_rdata  in  32  fetched instruction word
instr  out  32  latched instruction to decoder/datapath
instr_valid  out  1  instr is being executed this cycle (EXEC state)
branch  in  2  from decoder: 00 none, 01 beq, 10 bgez, 11 balrn
jump  in  1  from decoder: jmadd, target = mem_rdata
jpc  in  1  from decoder: PC-relative jump
memread  in  1  from decoder: instruction needs data memory
statusregwrite  in  1  from decoder: update Z/N flags
mem_ready  in  1  data memory read complete
mem_rdata  in  32  data memory read value (jmadd target)
rs_value  in  32  register rs read value (balrn target)
alu_zero  in  1  ALU result == 0
alu_neg  in  1  ALU result bit 31
pc  out  ADDR_W  current PC
link_addr  out  ADDR_W  PC+4, written to rd/$31 by the datapath
flag_z  out  1  status Z
flag_n  out  1  status N

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, imem_req=0, instr=0, instr_valid=0, flag_z=0, flag_n=0.
  - An in-flight fetch is abandoned.
  - imem_req rises in the first clk edge after deassertion.
- FSM states FETCH and EXEC:
  - FETCH: imem_req=1, imem_addr=pc, instr_valid=0. On imem_valid=1: instr<=imem_rdata, go to EXEC. No timeout; waits indefinitely.
  - EXEC: imem_req=0, instr_valid=1, decoder/datapath evaluate combinationally from instr. imem_valid is ignored.
    - Stall: if memread=1 and mem_ready=0, stay in EXEC. pc and flags are held and instr_valid stays 1.
    - Retire: otherwise, on the clock edge update pc to next_pc, update flags, go to FETCH.
  - Minimum 2 cycles per instruction: 1 fetch (zero-wait memory) + 1 execute.
- next_pc, evaluated in EXEC; priority is first match:
  1. jump=1 -> mem_rdata
  2. jpc=1 -> pc+4+(sext(instr[15:0])<<2)
  3. branch=11 and flag_n=1 -> rs_value
  4. branch=01 and alu_zero=1 -> pc+4+(sext(imm)<<2)
  5. branch=10 and alu_neg=0 -> pc+4+(sext(imm)<<2)
  6. otherwise pc+4
- Target rules:
  - All targets have bits[1:0] forced to 00.
  - Arithmetic is modulo 2^ADDR_W; wrap from 32'hFFFF_FFFC to 0 is legal.
- link_addr = pc+4 combinationally. It is valid during EXEC.
- balrn reads flag_n as registered before this instruction, so its own result is not used. This is why the decoder drives statusregwrite=0 for balrn.
- Flags: at retire, if statusregwrite=1 then flag_z<=alu_zero and flag_n<=alu_neg; otherwise they hold.
  - Flags do not change during a stall or in FETCH.
- Simultaneous jump and jpc (illegal decode): jump wins by the priority above.

Test Plan:
- Reset with RESET_PC=32'h100, release -> imem_req=1, imem_addr=32'h100. Return any word with imem_valid delayed 3 cycles -> instr_valid high exactly 1 cycle, then pc=32'h104.
- beq, imm=16'hFFFE, pc=32'h200, alu_zero=1 -> pc=32'h1FC. Same with alu_zero=0 -> pc=32'h204.
- bgez, imm=4, pc=32'h40: alu_neg=0 -> pc=32'h54; alu_neg=1 -> pc=32'h44.
- sub retiring with alu_neg=1, statusregwrite=1, then balrn with rs_value=32'h300 -> flag_n=1, pc=32'h300, link_addr=old pc+4. Repeat with flag_n=0 -> pc+4.
- jmadd (jump=1, memread=1) with mem_ready low 2 cycles, mem_rdata=32'h8002 -> pc holds for 2 cycles, then pc=32'h8000.
- Assert rst_n low in FETCH while imem_valid=1 -> pc=RESET_PC, instr=0, no transition to EXEC. jpc at pc=32'hFFFF_FFFC with imm=0 -> pc=32'h0.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// fetch_pc_unit_if: instruction-memory request/response bus between the fetch unit and imem
//   req   : fetch request, driven by the fetch unit
//   addr  : fetch address, driven by the fetch unit
//   valid : imem returns rdata this cycle
//   rdata : fetched instruction word
interface fetch_pc_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic [31:0]       rdata;
    modport master (output req, addr, input valid, rdata);
    modport slave  (input req, addr, output valid, rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC register, FETCH/EXEC sequencing, next-PC selection and Z/N status flags
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem              : instruction-memory bus (master side)
//   instr/instr_valid : latched instruction and its execute strobe
//   branch/jump/jpc/memread/statusregwrite : decoder controls
//   mem_ready/mem_rdata, rs_value, alu_zero/alu_neg : datapath inputs
//   pc/link_addr      : current PC and PC+4
//   flag_z/flag_n     : status flags
module fetch_pc_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_pc_unit_if.master   imem,
    output logic [31:0]       instr,
    output logic              instr_valid,
    input  logic [1:0]        branch,
    input  logic              jump,
    input  logic              jpc,
    input  logic              memread,
    input  logic              statusregwrite,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    input  logic [31:0]       rs_value,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr,
    output logic              flag_z,
    output logic              flag_n
);
    typedef enum logic {FETCH, EXEC} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_plus4, br_tgt, target;
    logic [31:0]       instr_q, instr_d;
    logic              flag_z_q, flag_z_d, flag_n_q, flag_n_d;
    // req is registered so it stays low during reset and rises on the first edge after it
    logic              req_q, req_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
            req_q    <= req_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;
        pc_plus4 = pc_q + ADDR_W'(4);
        br_tgt   = pc_plus4 + ADDR_W'({{14{instr_q[15]}}, instr_q[15:0], 2'b00});
        // balrn tests the flag as it stood before this instruction
        target   = jump                             ? ADDR_W'(mem_rdata) :
                   jpc                              ? br_tgt :
                   (branch == 2'b11 && flag_n_q)    ? ADDR_W'(rs_value) :
                   (branch == 2'b01 && alu_zero)    ? br_tgt :
                   (branch == 2'b10 && !alu_neg)    ? br_tgt : pc_plus4;
        if (state_q == FETCH) begin
            if (req_q && imem.valid) begin
                instr_d = imem.rdata;
                state_d = EXEC;
            end
        end else if (!(memread && !mem_ready)) begin
            pc_d    = {target[ADDR_W-1:2], 2'b00};
            state_d = FETCH;
            if (statusregwrite) begin
                flag_z_d = alu_zero;
                flag_n_d = alu_neg;
            end
        end
        req_d = state_d == FETCH;
    end
    assign imem.req    = req_q;
    assign imem.addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = state_q == EXEC;
    assign pc          = pc_q;
    assign link_addr   = pc_plus4;
    assign flag_z      = flag_z_q;
    assign flag_n      = flag_n_q;
endmodule
